// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority winner search
// for the eight-way bus arbiter.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    // Scan ptr+1, ptr+2, ... mod 8 and return the first requester found.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux8.sv
// Eight-input data multiplexer steering the current owner's
// data onto the shared output channel.
module mux8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [W-1:0] d4,
    input  logic [W-1:0] d5,
    input  logic [W-1:0] d6,
    input  logic [W-1:0] d7,
    input  logic [2:0]   s,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        unique case (s)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter granting bounded bursts from eight requesters
// onto one valid/ready output channel.
module bus_arbiter8
    import arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       in0,
    input  logic [W-1:0]       in1,
    input  logic [W-1:0]       in2,
    input  logic [W-1:0]       in3,
    input  logic [W-1:0]       in4,
    input  logic [W-1:0]       in5,
    input  logic [W-1:0]       in6,
    input  logic [W-1:0]       in7,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   sel,
    output logic [W-1:0]       out,
    output logic               out_valid,
    output logic [NUM_REQ-1:0] ack
);

    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         count_q, count_d;
    logic [IDX_W-1:0]   win;
    logic               accept;

    assign win       = rr_pick(req, ptr_q);
    assign out_valid = (state_q == BUSY) && req[sel_q];
    assign accept    = out_valid && out_ready;
    assign ack       = accept ? grant_q : '0;
    assign grant     = grant_q;
    assign sel       = sel_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = NUM_REQ'(1) << win;
                    sel_d   = win;
                    ptr_d   = win;
                    count_d = '0;
                end
            end
            BUSY: begin
                // A final beat coinciding with a req drop releases only once.
                if (!req[sel_q] || (accept && count_q == LAST)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                end else if (accept) begin
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    mux8 #(.W(W)) u_mux (
        .d0(in0), .d1(in1), .d2(in2), .d3(in3),
        .d4(in4), .d5(in5), .d6(in6), .d7(in7),
        .s (sel_q),
        .y (out)
    );

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed-vector bench for the round-robin bus arbiter.
module tb_bus_arbiter8;

    logic       clock = 1'b0;
    logic       reset_L;
    logic [7:0] req;
    logic [7:0] din [8];
    logic       out_ready;
    logic [7:0] grant;
    logic [2:0] sel;
    logic [7:0] out;
    logic       out_valid;
    logic [7:0] ack;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bus_arbiter8 #(.W(8), .MAX_BURST(4)) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .req      (req),
        .in0      (din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4      (din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .out_ready(out_ready),
        .grant    (grant),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid),
        .ack      (ack)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00;
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    task automatic go_idle();
        req = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        req = 8'hFF;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            checks++;
            if (grant !== 8'h00 || out_valid !== 1'b0 || ack !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold c%0d grant=%h valid=%b ack=%h want 00/0/00",
                         c, grant, out_valid, ack);
            end
        end
        reset_L = 1'b1;
        tick();
        #1;
        checks++;
        if (grant !== 8'h01) begin
            errors++;
            $display("FAIL reset_release grant=%h want 01", grant);
        end
        go_idle();
    endtask

    task automatic test_single();
        req = 8'h04;
        out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (grant !== 8'h04 || sel !== 3'd2 || out !== 8'hCA || ack !== 8'h04) begin
                errors++;
                $display("FAIL single_beat%0d grant=%h sel=%0d out=%h ack=%h want 04/2/ca/04",
                         b, grant, sel, out, ack);
            end
            tick();
        end
        #1;
        checks++;
        if (grant !== 8'h00 || ack !== 8'h00) begin
            errors++;
            $display("FAIL single_gap grant=%h ack=%h want 00/00", grant, ack);
        end
        tick();
        #1;
        checks++;
        if (grant !== 8'h04) begin
            errors++;
            $display("FAIL single_regrant grant=%h want 04", grant);
        end
        go_idle();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [3];
        logic [7:0] dexp [3];
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'h01;
        dexp[0] = 8'h10; dexp[1] = 8'h17; dexp[2] = 8'h10;
        do_reset();
        req = 8'h81;
        out_ready = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            for (int b = 0; b < 4; b++) begin
                #1;
                checks++;
                if (grant !== exp[g] || ack !== exp[g] || out !== dexp[g]) begin
                    errors++;
                    $display("FAIL rr_g%0d_b%0d grant=%h ack=%h out=%h want %h/%h/%h",
                             g, b, grant, ack, out, exp[g], exp[g], dexp[g]);
                end
                tick();
            end
            #1;
            checks++;
            if (grant !== 8'h00 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap%0d grant=%h valid=%b want 00/0", g, grant, out_valid);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        pat = 6'b111001;
        do_reset();
        req = 8'h20;
        tick();
        for (int c = 0; c < 6; c++) begin
            out_ready = pat[c];
            #1;
            checks++;
            if (grant !== 8'h20 || out_valid !== 1'b1 ||
                ack !== (pat[c] ? 8'h20 : 8'h00)) begin
                errors++;
                $display("FAIL bp_c%0d grant=%h valid=%b ack=%h want 20/1/%h",
                         c, grant, out_valid, ack, pat[c] ? 8'h20 : 8'h00);
            end
            tick();
        end
        #1;
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL bp_release grant=%h want 00", grant);
        end
        go_idle();
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 8'h08;
        out_ready = 1'b1;
        tick();
        req = 8'h48;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (grant !== 8'h08 || ack !== 8'h08 || out !== 8'h13) begin
                errors++;
                $display("FAIL drop_beat%0d grant=%h ack=%h out=%h want 08/08/13",
                         b, grant, ack, out);
            end
            tick();
        end
        req = 8'h40;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ack !== 8'h00 || grant !== 8'h08) begin
            errors++;
            $display("FAIL drop_fall valid=%b ack=%h grant=%h want 0/00/08",
                     out_valid, ack, grant);
        end
        tick();
        #1;
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL drop_gap grant=%h want 00", grant);
        end
        tick();
        #1;
        checks++;
        if (grant !== 8'h40 || sel !== 3'd6 || out !== 8'h16) begin
            errors++;
            $display("FAIL drop_next grant=%h sel=%0d out=%h want 40/6/16", grant, sel, out);
        end
        go_idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h02;
        out_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (ack !== 8'h02) begin
            errors++;
            $display("FAIL mid_beat1 ack=%h want 02", ack);
        end
        tick();
        reset_L = 1'b0;
        tick();
        #1;
        checks++;
        if (grant !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_kill grant=%h valid=%b want 00/0", grant, out_valid);
        end
        reset_L = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (grant !== 8'h02 || ack !== 8'h02) begin
                errors++;
                $display("FAIL mid_fresh%0d grant=%h ack=%h want 02/02", b, grant, ack);
            end
            tick();
        end
        #1;
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL mid_end grant=%h want 00", grant);
        end
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) din[i] = 8'h10 + 8'(i);
        din[2] = 8'hCA;
        reset_L = 1'b0;
        req = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Round-robin arbiter that shares one W-bit output channel among eight requesters. It grants one requester at a time and holds the grant for a bounded burst of beats. It steers the winner's data through an 8:1 multiplexer and presents it to a single consumer with a valid/ready handshake. It is the sequencing front end for shared resources such as the display writer and the score/RAM port.

## Interface

Parameters:
- W, 8: data width per requester and output.
- MAX_BURST, 4: maximum beats accepted per grant. Legal range is 1..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_L  in  1  synchronous, active-low reset.
- req  in  8  per-requester request; held high while the requester has data.
- in0..in7  in  W each  per-requester data; must be stable while req is high.
- out_ready  in  1  consumer accepts the beat this cycle.
- grant  out  8  one-hot registered grant, or all-zero.
- sel  out  3  index of current owner; drives mux select.
- out  out  W  data of the selected requester.
- out_valid  out  1  beat offered to the consumer.
- ack  out  8  one-hot; pulses for the owner in the cycle its beat is accepted.

## Operation

States are IDLE and BUSY.

Reset (reset_L low at posedge), same regardless of current state:
- State goes to IDLE.
- grant=0, sel=0, ptr=7, count=0.
- out_valid=0 and ack=0, because grant=0.

IDLE:
- If req is 0, stay in IDLE.
- Otherwise, the winner is the first set bit of req scanning ptr+1, ptr+2, … mod 8.
- Next cycle: grant=onehot(winner), sel=winner, ptr=winner, count=0, state BUSY.

BUSY:
- out_valid = req[sel] (combinational).
- out = in[sel] (combinational).
- A beat is accepted when out_valid && out_ready. In that cycle ack[sel]=1 and count increments.
- Go to IDLE at the next posedge, with grant=0, when either:
  - req[sel]=0 in that cycle, or
  - a beat is accepted and count==MAX_BURST-1.
- Otherwise stay in BUSY.

Rules:
- Requests from non-owners are ignored during BUSY.
- count is 8 bits wide and never exceeds MAX_BURST-1.
- ptr only updates on a new grant. The last owner therefore has lowest priority in the next arbitration.
- Simultaneous final beat and req drop: leave for IDLE once, with no extra beat.
- out_ready high with out_valid low: no effect.

## Timing

- Arbitration latency: req rises in IDLE at cycle N, grant and out_valid are high at N+1.
- Turnaround: one mandatory IDLE cycle between grants. Even the same requester re-winning has a one-cycle gap.
- Throughput: up to MAX_BURST beats in MAX_BURST cycles when out_ready is held high.
- Back-to-back bursts from competing requesters: MAX_BURST beats, one idle cycle, then MAX_BURST beats.
- Combinational paths:
  - out and out_valid depend on the registered sel/grant plus req and in*.
  - ack depends on out_ready.
  - There is no combinational path from out_ready to grant.
- Reset is sampled only at posedge. A mid-burst reset kills the burst, and the partial count is discarded.

## Structure

- Shared package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t
  - localparam NUM_REQ = 8
  - localparam IDX_W = 3
- The priority-rotate winner search is a function in arb_pkg.
- Datapath is one instance of the existing mux8 (W passed through), with select=sel.
- FSM, ptr and count registers live in a single always_ff in bus_arbiter8.

## Test plan

- Reset: hold reset_L=0 for 2 cycles with req=8'hFF.
  - Required: grant=0, out_valid=0, ack=0 throughout.
  - First release: grant=8'h01 one cycle after reset_L=1, since ptr=7.
- Single requester: req=8'h04, in2=8'hCA, out_ready=1, MAX_BURST=4.
  - Required: grant=8'h04, sel=2, out=8'hCA.
  - Four ack[2] pulses, then one IDLE cycle, then re-grant to requester 2.
- Round-robin: req=8'h81 held, out_ready=1.
  - Required: grants alternate 8'h01, 8'h80, 8'h01, each burst 4 beats with a 1-cycle gap.
- Backpressure: owner 5, out_ready toggled 1,0,0,1,1,1.
  - Required: ack[5] only on ready cycles.
  - Grant releases after the 4th accepted beat (cycle 6), not after 4 cycles.
- Early drop: owner 3 drops req after 2 accepted beats while req[6]=1.
  - Required: out_valid falls immediately, grant=0 for one cycle, then grant=8'h40.
- Mid-burst reset: reset_L=0 during the 2nd beat of owner 1.
  - Required: next cycle grant=0 and count=0.
  - After release with req=8'h02, a fresh 4-beat burst begins.
